// File: rtl/spi_logic_slave_pkg.sv
// Shared SPI definitions: FSM states, SPI_CTRL bit positions and word-length decode.
// Used by both the SPI master and slave blocks.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_e;

   localparam int unsigned CTRL_EN        = 0;
   localparam int unsigned CTRL_CPHA      = 1;
   localparam int unsigned CTRL_CPOL      = 2;
   localparam int unsigned CTRL_LSB_FIRST = 3;
   localparam int unsigned CTRL_LEN_LO    = 4;
   localparam int unsigned CTRL_LEN_HI    = 5;
   localparam int unsigned CTRL_IRQ_EN    = 6;
   localparam int unsigned CTRL_IRQ_CLR   = 7;

   localparam logic [1:0] LEN_8  = 2'b00;
   localparam logic [1:0] LEN_16 = 2'b01;

   function automatic logic [6:0] len_bits(input logic [1:0] len);
      case (len)
         LEN_8:   return 7'd8;
         LEN_16:  return 7'd16;
         default: return 7'd32;
      endcase
   endfunction

endpackage

// File: rtl/spi_logic_slave_if.sv
// CPU register bus plus SPI pins of the SPI slave, grouped for port connection.
interface spi_logic_slave_if #(
   parameter int unsigned DATA_W = 32
) ();

   logic [8:0]        SPI_CTRL;
   logic [DATA_W-1:0] SPI_DATA_OUT;
   logic [DATA_W-1:0] SPI_DATA_IN;
   logic              SPI_BUSY;
   logic              SPI_OVR;
   logic              IRQ_SPI;
   logic              SCK;
   logic              MOSI;
   logic              SS;
   logic              MISO;
   logic              MISO_OE;

   modport slave (
      input  SPI_CTRL, SPI_DATA_OUT, SCK, MOSI, SS,
      output SPI_DATA_IN, SPI_BUSY, SPI_OVR, IRQ_SPI, MISO, MISO_OE
   );

   modport master (
      output SPI_CTRL, SPI_DATA_OUT, SCK, MOSI, SS,
      input  SPI_DATA_IN, SPI_BUSY, SPI_OVR, IRQ_SPI, MISO, MISO_OE
   );

endinterface

// File: rtl/spi_logic_slave_sync_edge.sv
// Multi-flop synchronizer with a one-cycle toggle pulse; direction is read from o_q.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_q    = r_sync[SYNC_STAGES-1];
   assign o_edge = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/spi_logic_slave.sv
// SPI slave: oversampled SCK/SS/MOSI, all CPOL/CPHA modes, 8/16/32-bit words,
// received word and sticky IRQ/overrun flags presented on the CPU register bus.
module spi_logic_slave
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic               clk_cpu,
   input logic               rst,
   spi_logic_slave_if.slave  bus
);

   localparam logic [6:0] DW = 7'(DATA_W);

   spi_state_e        r_state, w_state_nxt;
   logic [DATA_W-1:0] r_tx, r_rx, r_data_in;
   logic [6:0]        r_bit_cnt, r_len;
   logic              r_cpha, r_cpol, r_lsb, r_miso, r_irq, r_ovr;
   logic [SYNC_STAGES-1:0] r_mosi_sync;

   logic w_sck_q, w_sck_edge, w_ss_q, w_ss_edge, w_ss_fall;
   logic w_lead, w_trail, w_sample, w_advance, w_load, w_done;
   logic w_en, w_ld_cpha, w_ld_lsb, w_mosi;
   logic [6:0] w_ld_len;
   logic [DATA_W-1:0] w_rx_word;

   function automatic logic f_head(input logic [DATA_W-1:0] x, input logic [6:0] len,
                                   input logic lsb);
      logic [DATA_W-1:0] t;
      t = x >> (len - 7'd1);
      return lsb ? x[0] : t[0];
   endfunction

   function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] x, input logic lsb);
      return lsb ? (x >> 1) : (x << 1);
   endfunction

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk_cpu), .rst_n(rst), .i_d(bus.SCK), .o_q(w_sck_q), .o_edge(w_sck_edge)
   );

   // SS resets high so MISO_OE is low throughout reset.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk(clk_cpu), .rst_n(rst), .i_d(bus.SS), .o_q(w_ss_q), .o_edge(w_ss_edge)
   );

   always_ff @(posedge clk_cpu or negedge rst) begin
      if (!rst) r_mosi_sync <= '0;
      else      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
   end

   assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
   assign w_en      = bus.SPI_CTRL[CTRL_EN];
   assign w_ss_fall = w_ss_edge & ~w_ss_q;
   assign w_lead    = w_sck_edge & (w_sck_q != r_cpol);
   assign w_trail   = w_sck_edge & (w_sck_q == r_cpol);
   assign w_ld_cpha = bus.SPI_CTRL[CTRL_CPHA];
   assign w_ld_lsb  = bus.SPI_CTRL[CTRL_LSB_FIRST];
   assign w_ld_len  = len_bits(bus.SPI_CTRL[CTRL_LEN_HI:CTRL_LEN_LO]);
   assign w_rx_word = r_lsb ? (r_rx >> (DW - r_len)) : r_rx;

   always_ff @(posedge clk_cpu or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_en && w_ss_fall) w_state_nxt = SHIFT;
         SHIFT: begin
            if (!w_en || w_ss_q)
               w_state_nxt = IDLE;
            else if (w_sample && (r_bit_cnt == r_len - 7'd1))
               w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = w_ss_q ? IDLE : SHIFT;
         default: w_state_nxt = IDLE;
      endcase
   end

   // In CPHA=0 the trailing edge of the previous word's last bit arrives after the
   // reload; bit_cnt==0 marks it as stale so bit 0 of the new word is not skipped.
   always_comb begin
      w_sample  = 1'b0;
      w_advance = 1'b0;
      w_load    = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         IDLE:  w_load = (w_state_nxt == SHIFT);
         SHIFT: begin
            w_sample  = r_cpha ? w_trail : w_lead;
            w_advance = r_cpha ? w_lead : (w_trail && (r_bit_cnt != 7'd0));
         end
         DONE: begin
            w_done = 1'b1;
            w_load = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_cpu or negedge rst) begin
      if (!rst) begin
         r_tx      <= '0;
         r_rx      <= '0;
         r_bit_cnt <= '0;
         r_len     <= 7'd8;
         r_cpha    <= 1'b0;
         r_cpol    <= 1'b0;
         r_lsb     <= 1'b0;
         r_miso    <= 1'b0;
      end else if (w_load) begin
         r_cpha    <= w_ld_cpha;
         r_cpol    <= bus.SPI_CTRL[CTRL_CPOL];
         r_lsb     <= w_ld_lsb;
         r_len     <= w_ld_len;
         r_bit_cnt <= '0;
         r_rx      <= '0;
         if (!w_ld_cpha) begin
            r_miso <= f_head(bus.SPI_DATA_OUT, w_ld_len, w_ld_lsb);
            r_tx   <= f_shift(bus.SPI_DATA_OUT, w_ld_lsb);
         end else begin
            r_miso <= 1'b0;
            r_tx   <= bus.SPI_DATA_OUT;
         end
      end else begin
         if (w_sample) begin
            r_rx      <= r_lsb ? {w_mosi, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 7'd1;
         end
         if (w_advance) begin
            r_miso <= f_head(r_tx, r_len, r_lsb);
            r_tx   <= f_shift(r_tx, r_lsb);
         end
      end
   end

   always_ff @(posedge clk_cpu or negedge rst) begin
      if (!rst) begin
         r_data_in <= '0;
         r_irq     <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         if (w_done) r_data_in <= w_rx_word;
         if (bus.SPI_CTRL[CTRL_IRQ_CLR]) begin
            r_irq <= 1'b0;
            r_ovr <= 1'b0;
         end else if (w_done) begin
            if (r_irq) r_ovr <= 1'b1;
            r_irq <= bus.SPI_CTRL[CTRL_IRQ_EN];
         end
      end
   end

   assign bus.SPI_DATA_IN = r_data_in;
   assign bus.SPI_BUSY    = (r_state != IDLE);
   assign bus.SPI_OVR     = r_ovr;
   assign bus.IRQ_SPI     = r_irq;
   assign bus.MISO_OE     = w_en & ~w_ss_q;
   assign bus.MISO        = bus.MISO_OE & r_miso;

endmodule

// File: doc/spi_logic_slave.md
Name: spi_logic_slave

Overview:
SPI responder (slave) end of the SPI link driven by spi_logic_master; lets a RISC-V core act as an SPI peripheral. Oversamples SCK/SS/MOSI on clk_cpu, supports all four CPOL/CPHA modes and 8/16/32-bit words, and drives MISO from a CPU-loaded word. Completed words go to SPI_DATA_IN and raise IRQ_SPI. Sits on the same CPU register bus as the master block.

Parameters:
DATA_W, 32, maximum word width / SPI_DATA_IN, SPI_DATA_OUT width
SYNC_STAGES, 2, flip-flop stages on SCK, SS, MOSI (minimum 2)

Ports:
clk_cpu  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
SPI_CTRL  in  9  [0] EN, [1] CPHA, [2] CPOL, [3] LSB_FIRST, [5:4] LEN (00=8, 01=16, 1x=32), [6] IRQ_EN, [7] IRQ_CLR (level), [8] reserved (ignored)
SPI_DATA_OUT  in  DATA_W  word returned to the master, right-justified
SPI_DATA_IN  out  DATA_W  last completed received word, right-justified, upper bits zero
SPI_BUSY  out  1  high while a word is in progress
SPI_OVR  out  1  sticky overrun flag; cleared by IRQ_CLR
SCK  in  1  serial clock from master (asynchronous)
MOSI  in  1  serial data from master
SS  in  1  slave select, active-low
MISO  out  1  serial data to master
MISO_OE  out  1  MISO output enable for the pad tri-state
IRQ_SPI  out  1  word-complete interrupt, level, sticky until IRQ_CLR

Behaviour:
- Reset (rst=0): all outputs 0, FSM IDLE, shift registers and bit counter 0.
- SCK, SS, MOSI pass through SYNC_STAGES flops. Edges are detected on the synced SCK, so latency is SYNC_STAGES+1 clk_cpu cycles. The supported SCK frequency is at most clk_cpu/8.
- Leading edge: SCK leaves its CPOL idle level. Trailing edge: SCK returns to it.
- FSM IDLE:
  - Enter SHIFT on synced SS falling edge with EN=1.
  - On entry, load tx_sh from SPI_DATA_OUT, clear bit_cnt, set SPI_BUSY=1.
- FSM SHIFT:
  - CPHA=0: MISO presents bit 0 of the word immediately on entry. Sample MOSI on the leading edge; advance MISO on the trailing edge.
  - CPHA=1: advance MISO on the leading edge (the first leading edge presents bit 0). Sample MOSI on the trailing edge.
  - Bit order: MSB of the LEN-bit word first unless LSB_FIRST=1. Bits of SPI_DATA_OUT above LEN are ignored.
  - After LEN samples, go to DONE for 1 cycle.
- FSM DONE:
  - SPI_DATA_IN <= received word, zero-extended.
  - If IRQ_SPI is already 1, set SPI_OVR=1. Then IRQ_SPI <= IRQ_EN.
  - Reload tx_sh from SPI_DATA_OUT and clear bit_cnt.
  - Return to SHIFT if SS is still low (back-to-back words); otherwise go to IDLE with SPI_BUSY=0.
- SS rise while in SHIFT (abort):
  - Partial word is discarded; SPI_DATA_IN, IRQ_SPI and SPI_OVR are unchanged.
  - Go to IDLE, SPI_BUSY=0.
- SCK edges while SS is high: ignored.
- MISO_OE = EN & synced SS low. MISO=0 whenever MISO_OE=0.
- EN cleared mid-word: same as abort, in the next cycle.
- IRQ_CLR=1:
  - Holds IRQ_SPI and SPI_OVR at 0.
  - If a word completes in the same cycle, clear wins, but SPI_DATA_IN still updates.
- CPOL, CPHA, LEN and LSB_FIRST are sampled at IDLE→SHIFT. Changes while SPI_BUSY=1 take effect at the next word.
- rst asserted mid-transfer: immediate return to the reset state. MISO_OE drops asynchronously.

Decomposition:
- Package spi_pkg: FSM state encoding (IDLE, SHIFT, DONE), SPI_CTRL bit-index constants (CTRL_EN … CTRL_IRQ_CLR), LEN decode constants. These are shared with spi_logic_master.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated for SCK and SS. MOSI uses a synchronizer only.

Test Plan:
1. Mode 0, LEN=8, MSB first: SPI_DATA_OUT=0xA5; master sends 0x3C with SCK=clk_cpu/10 → MISO bits 1,0,1,0,0,1,0,1; SPI_DATA_IN=0x0000003C; IRQ_SPI=1 four cycles after the 8th SCK rise; SPI_BUSY=0 after SS rise.
2. All four CPOL/CPHA modes, LEN=16: exchange 0x1234 / 0xBEEF → slave receives 0xBEEF and master receives 0x1234 in every mode. Loopback against spi_logic_master with matching CTRL.
3. LEN=32, LSB_FIRST=1, SPI_DATA_OUT=0x80000001 → first and last MISO bits are 1, all others 0; SPI_DATA_IN equals the MOSI word sent LSB-first.
4. Back-to-back: two 8-bit words 0x11, 0x22 under one SS low, no IRQ_CLR → SPI_DATA_IN=0x22, IRQ_SPI=1, SPI_OVR=1. Then IRQ_CLR pulse → both 0.
5. Abort: SS rises after 5 of 8 bits → SPI_DATA_IN keeps its prior value, IRQ_SPI stays 0, SPI_BUSY=0, MISO_OE=0.
6. Reset mid-word: rst=0 at bit 3 → all outputs 0 immediately. After release, a full 8-bit transfer of 0x5A succeeds. EN=0 → MISO_OE stays 0 and no IRQ.
